// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host scancode receiver.
// This module synchronises and deglitches the PS/2 clock and data lines, then deframes 11-bit frames.
// The E0 (extended) and F0 (break) prefixes are folded into flags, and one strobe is raised per key event.
// Optional feature: define PS2RX_PARITY_CHECK_EN to reject bytes whose parity is wrong.
module ps2_scan_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 56000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_rcv,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       kb_interrupt,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] fcnt;
  logic          fe;
  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          ext_pend, rel_pend;
  logic          parity_pass_c;

`ifdef PS2RX_PARITY_CHECK_EN
  logic par_bit;
  assign parity_pass_c = ^{shreg, par_bit};
`else
  assign parity_pass_c = 1'b1;
`endif

  // Two-flop synchronisers for both raw lines; idle level is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2clk_ext;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2data_ext;
      dat_s2 <= dat_s1;
    end
  end

  // Clock deglitch filter: flip only after FILTER_LEN consecutive differing samples, flag falling edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      fcnt     <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s2 == filt_clk) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        fcnt     <= '0;
        fe       <= filt_clk;
      end else begin
        fcnt <= FW'(fcnt + 1'b1);
      end
    end
  end

  // Frame deframer, timeout, prefix folding and event outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bitcnt       <= 3'd0;
      shreg        <= 8'h00;
      tcnt         <= '0;
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
      kb_interrupt <= 1'b0;
      frame_err    <= 1'b0;
      scancode     <= 8'h00;
      released     <= 1'b0;
      extended     <= 1'b0;
`ifdef PS2RX_PARITY_CHECK_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      kb_interrupt <= 1'b0;
      frame_err    <= 1'b0;
      if (!enable_rcv) begin
        // Host owns the line: drop any partial frame without complaint
        state <= S_IDLE;
        tcnt  <= '0;
      end else if (fe) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state  <= S_DATA;
              bitcnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= 3'(bitcnt + 1'b1);
            if (bitcnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2RX_PARITY_CHECK_EN
            par_bit <= dat_s2;
`endif
            state <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (dat_s2 && parity_pass_c) begin
              case (shreg)
                8'hE0: ext_pend <= 1'b1;
                8'hF0: rel_pend <= 1'b1;
                default: begin
                  scancode     <= shreg;
                  extended     <= ext_pend;
                  released     <= rel_pend;
                  kb_interrupt <= 1'b1;
                  ext_pend     <= 1'b0;
                  rel_pend     <= 1'b0;
                end
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= S_IDLE;
          frame_err <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= TW'(tcnt + 1'b1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed self-checking bench for ps2_scan_receiver (short timeout for run length).
module tb_ps2_scan_receiver;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_rcv;
  logic       ps2clk_ext;
  logic       ps2data_ext;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       released;
  logic       extended;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int n_irq  = 0;
  int n_err  = 0;
  int n_both = 0;
  int i0, e0;

  ps2_scan_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_rcv  (enable_rcv),
    .ps2clk_ext  (ps2clk_ext),
    .ps2data_ext (ps2data_ext),
    .kb_interrupt(kb_interrupt),
    .scancode    (scancode),
    .released    (released),
    .extended    (extended),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Count strobe cycles away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (kb_interrupt) n_irq++;
      if (frame_err) n_err++;
      if (kb_interrupt && frame_err) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2data_ext = b;
    tick(20);
    ps2clk_ext = 1'b0;
    tick(40);
    ps2clk_ext = 1'b1;
    tick(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    ps2data_ext = 1'b1;
    tick(40);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable_rcv  = 1'b1;
    ps2clk_ext  = 1'b1;
    ps2data_ext = 1'b1;
    // Reset while lines toggle
    for (int i = 0; i < 3; i++) begin
      ps2clk_ext  = i[0];
      ps2data_ext = ~i[0];
      tick(1);
    end
    @(negedge clk);
    check("rst_irq", 32'(kb_interrupt), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_code", 32'(scancode), 32'h00);
    check("rst_rel", 32'(released), 32'd0);
    check("rst_ext", 32'(extended), 32'd0);
    ps2clk_ext  = 1'b1;
    ps2data_ext = 1'b1;
    rst_n       = 1'b1;
    tick(50);
    check("post_rst_irq", 32'(n_irq), 32'd0);

    // Plain make code 0x1C
    send_frame(8'h1C, 1'b0);
    check("1c_irq", 32'(n_irq), 32'd1);
    check("1c_code", 32'(scancode), 32'h1C);
    check("1c_ext", 32'(extended), 32'd0);
    check("1c_rel", 32'(released), 32'd0);

    // Extended break E0 F0 75
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("pfx_no_irq", 32'(n_irq), 32'd1);
    send_frame(8'h75, 1'b0);
    check("75_irq", 32'(n_irq), 32'd2);
    check("75_code", 32'(scancode), 32'h75);
    check("75_ext", 32'(extended), 32'd1);
    check("75_rel", 32'(released), 32'd1);

    // Bad parity on 0x1C
    send_frame(8'h1C, 1'b1);
`ifdef PS2RX_PARITY_CHECK_EN
    check("par_ferr", 32'(n_err), 32'd1);
    check("par_irq", 32'(n_irq), 32'd2);
    check("par_code", 32'(scancode), 32'h75);
`else
    check("par_ferr", 32'(n_err), 32'd0);
    check("par_irq", 32'(n_irq), 32'd3);
    check("par_code", 32'(scancode), 32'h1C);
`endif

    // Following good 0x1C clears flags
    i0 = n_irq;
    e0 = n_err;
    send_frame(8'h1C, 1'b0);
    check("1c2_irq", 32'(n_irq), 32'(i0 + 1));
    check("1c2_code", 32'(scancode), 32'h1C);
    check("1c2_ext", 32'(extended), 32'd0);
    check("1c2_rel", 32'(released), 32'd0);

    // Short clock glitches with data low: no frame may start
    ps2data_ext = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2clk_ext = 1'b0;
      tick(FILT - 1);
      ps2clk_ext = 1'b1;
      tick(20);
    end
    tick(TMO + 200);
    check("glitch_ferr", 32'(n_err), 32'(e0));
    check("glitch_irq", 32'(n_irq), 32'(i0 + 1));

    // Partial frame then idle beyond timeout
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2data_ext = 1'b1;
    tick(TMO + 200);
    check("tmo_ferr", 32'(n_err), 32'(e0 + 1));
    check("tmo_irq", 32'(n_irq), 32'(i0 + 1));

    send_frame(8'h29, 1'b0);
    check("29_irq", 32'(n_irq), 32'(i0 + 2));
    check("29_code", 32'(scancode), 32'h29);
    check("29_ferr", 32'(n_err), 32'(e0 + 1));

    // Enable dropped mid-frame after 5 bits
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2data_ext = 1'b1;
    enable_rcv  = 1'b0;
    tick(100);
    enable_rcv = 1'b1;
    tick(100);
    send_frame(8'h5A, 1'b0);
    check("en_ferr", 32'(n_err), 32'(e0 + 1));
    check("en_irq", 32'(n_irq), 32'(i0 + 3));
    check("en_code", 32'(scancode), 32'h5A);

    check("never_both", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
